// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register file write port between the WB stage
// and a queued multiply/divide result stream. MDU results wait in a small FIFO
// and retire in idle WB slots. If the FIFO head is passed over STARVE_MAX times
// in a row, WB is stalled so that the head can retire.
module regfile_wr_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  output logic        wb_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_wa,
  input  logic [31:0] mdu_wd,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [4:0]       wa_mem [DEPTH];
  logic [31:0]      wd_mem [DEPTH];
  logic [31:0]      slot_mask [DEPTH];
  logic [31:0]      busy_or;

  logic empty, full, accept, push, pop;
  logic wb_eff, force_grant, grant_fifo, grant_wb;

  // The occupancy flags come only from registered state. This means a pop
  // in the same cycle can never open room for a push.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign mdu_ready = rst_n & ~full;

  // A result for x0 completes the handshake, but the FIFO never stores it.
  assign accept = mdu_valid & mdu_ready;
  assign push   = accept & (mdu_wa != 5'd0);

  // A WB write to x0 is no request at all. While reset is held, WB gets no grant.
  assign wb_eff = rst_n & wb_we & (wb_wa != 5'd0);

  assign force_grant = ~empty & (starve_q == SW'(STARVE_MAX));
  assign grant_fifo  = ~empty & (force_grant | ~wb_eff);
  assign grant_wb    = wb_eff & ~force_grant;
  assign pop         = grant_fifo;
  assign wb_stall    = force_grant;

  // Drive the write port from the granted source. An idle port outputs all zeros.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 32'd0;
    if (grant_fifo) begin
      rf_we = 1'b1;
      rf_wa = wa_mem[rd_ptr_q];
      rf_wd = wd_mem[rd_ptr_q];
    end else if (grant_wb) begin
      rf_we = 1'b1;
      rf_wa = wb_wa;
      rf_wd = wb_wd;
    end
  end

  // Next state of the pointers, the occupancy and the starvation counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    starve_d = starve_q;

    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (empty || grant_fifo) begin
      starve_d = '0;
    end else if (grant_wb && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Control state register. An asynchronous reset discards any queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      starve_q <= starve_d;
    end
  end

  // FIFO payload storage. valid_q qualifies every read, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem[wr_ptr_q] <= mdu_wa;
      wd_mem[wr_ptr_q] <= mdu_wd;
    end
  end

  // Each occupied slot contributes a one-hot mask of its destination register.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_mask
    assign slot_mask[gi] = valid_q[gi] ? (32'd1 << wa_mem[gi]) : 32'd0;
  end

  // The busy bitmap is the OR of the masks of all occupied slots.
  always_comb begin
    busy_or = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_or = busy_or | slot_mask[i];
    end
  end

  assign busy = busy_or;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random stimulus for regfile_wr_arbiter.
// A queue-based model of the result FIFO and the arbitration rules predicts the
// outputs on every cycle.
module tb_regfile_wr_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b1;
  logic [4:0]  wb_wa = 5'd5;
  logic [31:0] wb_wd = 32'h0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_wa = 5'd0;
  logic [31:0] mdu_wd = 32'h0;
  logic        wb_stall, mdu_ready, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, busy;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy)
  );

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t q[$];
  int   starve = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic        o_we, o_stall, o_ready;
  logic [4:0]  o_wa;
  logic [31:0] o_wd, o_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    o_we = rf_we; o_wa = rf_wa; o_wd = rf_wd;
    o_stall = wb_stall; o_ready = mdu_ready; o_busy = busy;
  endtask

  // One clock cycle. This task drives the inputs at posedge+1 and checks the
  // outputs against the model at the falling edge. The model then advances at
  // the rising edge.
  task automatic cycle(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mv, input logic [4:0] mwa,
                       input logic [31:0] mwd);
    logic        e_we, e_stall, e_ready;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_busy;
    bit          pop_f, push_f;
    ent_t        e;
    wb_we = we; wb_wa = wa; wb_wd = wd;
    mdu_valid = mv; mdu_wa = mwa; mdu_wd = mwd;
    #4;
    e_ready = (q.size() < DEPTH);
    e_busy  = 32'd0;
    foreach (q[i]) e_busy[q[i].wa] = 1'b1;
    e_stall = 1'b0; pop_f = 1'b0;
    e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
    if (q.size() > 0 && starve == STARVE_MAX) begin
      e_stall = 1'b1; pop_f = 1'b1;
    end else if (we && wa != 5'd0) begin
      e_we = 1'b1; e_wa = wa; e_wd = wd;
    end else if (q.size() > 0) begin
      pop_f = 1'b1;
    end
    if (pop_f) begin
      e_we = 1'b1; e_wa = q[0].wa; e_wd = q[0].wd;
    end
    sample();
    chk({tag, ".rf_we"}, {31'd0, o_we}, {31'd0, e_we});
    chk({tag, ".rf_wa"}, {27'd0, o_wa}, {27'd0, e_wa});
    chk({tag, ".rf_wd"}, o_wd, e_wd);
    chk({tag, ".wb_stall"}, {31'd0, o_stall}, {31'd0, e_stall});
    chk({tag, ".mdu_ready"}, {31'd0, o_ready}, {31'd0, e_ready});
    chk({tag, ".busy"}, o_busy, e_busy);
    $display("cyc %0d %s: wb_we=%0b wa=%0d mdu_v=%0b mwa=%0d -> rf_we=%0b rf_wa=%0d rf_wd=%08h stall=%0b ready=%0b busy=%08h",
             cyc, tag, we, wa, mv, mwa, o_we, o_wa, o_wd, o_stall, o_ready, o_busy);
    @(posedge clk);
    cyc++;
    push_f = mv && e_ready && (mwa != 5'd0);
    if (q.size() == 0 || pop_f) starve = 0;
    else if (starve < STARVE_MAX) starve++;
    if (pop_f) void'(q.pop_front());
    if (push_f) begin
      e.wa = mwa; e.wd = mwd;
      q.push_back(e);
    end
    #1;
  endtask

  // Asserts the asynchronous reset mid-cycle and checks that all outputs drop
  // at once, whatever the inputs are.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    sample();
    chk({tag, ".rf_we"}, {31'd0, o_we}, 32'd0);
    chk({tag, ".rf_wa"}, {27'd0, o_wa}, 32'd0);
    chk({tag, ".rf_wd"}, o_wd, 32'd0);
    chk({tag, ".wb_stall"}, {31'd0, o_stall}, 32'd0);
    chk({tag, ".mdu_ready"}, {31'd0, o_ready}, 32'd0);
    chk({tag, ".busy"}, o_busy, 32'd0);
    $display("cyc %0d %s: reset asserted", cyc, tag);
    q.delete();
    starve = 0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset is held with a WB request present. Release happens at posedge+1.
    @(posedge clk); #1;
    do_reset("rst");
    cycle("post_rst", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("post_rst.ready_explicit", {31'd0, o_ready}, 32'd1);

    // WB only
    cycle("wb7", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("wb7.we", {31'd0, o_we}, 32'd1);
    chk("wb7.wa", {27'd0, o_wa}, 32'd7);
    chk("wb7.wd", o_wd, 32'hDEADBEEF);
    cycle("wb0", 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("wb0.we", {31'd0, o_we}, 32'd0);

    // MDU result into an idle port
    cycle("mdu3_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h12345678);
    chk("mdu3_push.we", {31'd0, o_we}, 32'd0);
    cycle("mdu3_wr", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("mdu3_wr.busy3", {31'd0, o_busy[3]}, 32'd1);
    chk("mdu3_wr.wa", {27'd0, o_wa}, 32'd3);
    chk("mdu3_wr.wd", o_wd, 32'h12345678);
    cycle("mdu3_done", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("mdu3_done.busy", o_busy, 32'd0);

    // Starvation: WB keeps the port busy. The FIFO head is forced out on the 5th cycle.
    cycle("stv_push", 1'b1, 5'd1, 32'hAAAA0000, 1'b1, 5'd9, 32'h99999999);
    for (int k = 0; k < STARVE_MAX; k++) begin
      cycle("stv_wb", 1'b1, 5'd1, 32'hAAAA0001 + k, 1'b0, 5'd0, 32'd0);
      chk("stv_wb.wa", {27'd0, o_wa}, 32'd1);
      chk("stv_wb.stall", {31'd0, o_stall}, 32'd0);
    end
    cycle("stv_force", 1'b1, 5'd1, 32'hAAAA00FF, 1'b0, 5'd0, 32'd0);
    chk("stv_force.stall", {31'd0, o_stall}, 32'd1);
    chk("stv_force.wa", {27'd0, o_wa}, 32'd9);
    cycle("stv_resume", 1'b1, 5'd1, 32'hAAAA00FF, 1'b0, 5'd0, 32'd0);
    chk("stv_resume.stall", {31'd0, o_stall}, 32'd0);
    chk("stv_resume.wa", {27'd0, o_wa}, 32'd1);

    // Full FIFO: the third result is held off. The queued entries retire in order.
    cycle("full_p10", 1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0A0A0A0);
    cycle("full_p11", 1'b1, 5'd1, 32'h2, 1'b1, 5'd11, 32'hB0B0B0B0);
    cycle("full_blk", 1'b1, 5'd1, 32'h3, 1'b1, 5'd12, 32'hC0C0C0C0);
    chk("full_blk.ready", {31'd0, o_ready}, 32'd0);
    cycle("full_d10", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("full_d10.wa", {27'd0, o_wa}, 32'd10);
    cycle("full_d11", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("full_d11.wa", {27'd0, o_wa}, 32'd11);
    chk("full_d11.ready", {31'd0, o_ready}, 32'd1);
    cycle("full_empty", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("full_empty.we", {31'd0, o_we}, 32'd0);

    // An x0 result is accepted but then discarded.
    cycle("x0_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77777777);
    cycle("x0_chk", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("x0_chk.busy", o_busy, 32'd0);
    chk("x0_chk.we", {31'd0, o_we}, 32'd0);

    // Alternating push and pop exercises pointer wrap-around.
    for (int i = 0; i <= 8; i++) begin
      cycle("alt", 1'b0, 5'd0, 32'd0, (i < 8), 5'(20 + i), 32'h1111 * i);
      if (i > 0) chk("alt.wa_order", {27'd0, o_wa}, 32'(19 + i));
    end

    // Random traffic with one mid-operation reset
    for (int n = 0; n < 500; n++) begin
      if (n == 250) do_reset("rnd_rst");
      cycle("rnd", ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of the 32x32 register file between the pipeline writeback stage (WB) and a multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained into idle WB slots. A starvation counter forces a WB stall so queued results always retire. The block also filters writes to x0 and exports a busy bitmap of registers with queued writes to the hazard unit.

## Interface
Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive non-granted cycles with FIFO non-empty before WB is forced to stall (≥1)

Ports:
- clk  input  1  rising-edge clock, same as register file
- rst_n  input  1  asynchronous, active-low reset
- wb_we  input  1  WB stage write request
- wb_wa  input  5  WB destination register
- wb_wd  input  32  WB write data
- wb_stall  output  1  hold WB (and upstream) this cycle; WB write not performed
- mdu_valid  input  1  MDU result valid
- mdu_wa  input  5  MDU destination register
- mdu_wd  input  32  MDU result data
- mdu_ready  output  1  FIFO can accept; transfer when mdu_valid && mdu_ready
- rf_we  output  1  register file write enable
- rf_wa  output  5  register file write address
- rf_wd  output  32  register file write data
- busy  output  32  bit r set when any valid FIFO entry targets register r

## Operation
- WB request is effective only when wb_we=1 and wb_wa≠0; wb_we with wb_wa=0 is ignored (no write, no grant).
- MDU push: on mdu_valid && mdu_ready, entry stored at tail unless mdu_wa=0 (accepted and discarded).
- mdu_ready = !full, from registered count only; no push when full even if a pop occurs that cycle.
- No bypass: a pushed entry is writable no earlier than the following cycle.
- Grant per cycle (combinational), priority order:
  1. FORCE: starve_cnt == STARVE_MAX and FIFO non-empty → grant FIFO head, wb_stall=1.
  2. WB effective request → grant WB, wb_stall=0.
  3. FIFO non-empty → grant FIFO head.
  4. Else rf_we=0.
- Grant FIFO: rf_we=1, rf_wa/rf_wd = head; head popped at clock edge.
- Grant WB: rf_we=1, rf_wa=wb_wa, rf_wd=wb_wd.
- When rf_we=0, rf_wa=0 and rf_wd=0.
- wb_stall asserted only in FORCE, regardless of wb_we.
- starve_cnt (sequential, saturating at STARVE_MAX): cleared when FIFO empty or FIFO granted; incremented when FIFO non-empty and WB granted.
- busy: OR of one-hot(wa) over valid entries, from registered state; clears the cycle after the entry's pop.
- Write ordering between WB and MDU to the same register is the hazard unit's responsibility (via busy); the arbiter does not reorder or merge.

## Timing
- Reset (rst_n=0, asynchronous): FIFO empty, pointers/count 0, starve_cnt 0. While asserted: rf_we=0, rf_wa=0, rf_wd=0, wb_stall=0, mdu_ready=0, busy=0. Reset mid-operation discards queued entries.
- First cycle after release: mdu_ready=1.
- WB write latency: 0 extra cycles (rf_we same cycle as wb_we, written at that edge).
- MDU write latency: ≥1 cycle after acceptance; exactly 1 when WB idle and FIFO was empty.
- Worst-case MDU retire: head written within STARVE_MAX+1 cycles of reaching the head.
- Full: count == DEPTH → mdu_ready=0 next cycle; a pop re-asserts mdu_ready the cycle after.
- Simultaneous push and pop (not full): count unchanged; pointers wrap modulo DEPTH.

## Test plan
- Reset: hold rst_n=0 with wb_we=1, wb_wa=5 → rf_we=0, mdu_ready=0, busy=0; release → mdu_ready=1 next cycle.
- WB only: wb_we=1, wb_wa=7, wb_wd=0xDEADBEEF → same-cycle rf_we=1, rf_wa=7, rf_wd=0xDEADBEEF; wb_wa=0 → rf_we=0.
- MDU into idle port: push (wa=3, wd=0x12345678) with wb_we=0 → busy[3]=1 next cycle and rf_we=1, rf_wa=3 that cycle; busy[3]=0 following cycle.
- Starvation: push wa=9 with wb_we=1 (wa=1) held continuously, STARVE_MAX=4 → WB granted 4 cycles, 5th cycle wb_stall=1, rf_wa=9; then WB resumes with wb_stall=0.
- Full: DEPTH=2, WB busy, push wa=10,11 → mdu_ready=0; third mdu_valid not accepted; entries retire in order 10 then 11.
- x0 filter and wrap: push wa=0 (accepted, busy unchanged, never written); 8 alternating push/pop cycles → all entries written in order, no loss or duplicate.
